// File: rtl/audio_meter_pkg.sv
// Shared constants for the level-meter datapath: default sample width, window length and
// full-scale helpers derived per sample width.
package audio_meter_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT    = 16;
    localparam int unsigned WINDOW_LENGTH_DEFAULT = 1024;

    // Largest positive code, +(2^(width-1)-1).
    function automatic logic [31:0] full_scale_pos(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    // Bit pattern of the most negative code, -2^(width-1).
    function automatic logic [31:0] full_scale_neg(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/signed_magnitude.sv
// Combinational absolute value of a two's-complement sample plus full-scale clip detect.
// The most negative code maps to 2^(DATA_WIDTH-1) with no saturation.
module signed_magnitude
    import audio_meter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [DATA_WIDTH-1:0] o_mag,
    output logic                  o_clip
);

    localparam logic [DATA_WIDTH-1:0] FS_POS = DATA_WIDTH'(full_scale_pos(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] FS_NEG = DATA_WIDTH'(full_scale_neg(DATA_WIDTH));

    always_comb begin
        o_mag  = i_data[DATA_WIDTH-1] ? (~i_data + DATA_WIDTH'(1)) : i_data;
        o_clip = (i_data == FS_POS) || (i_data == FS_NEG);
    end

endmodule

// File: rtl/audio_peak_window.sv
// Tracks the peak magnitude and clip status over windows of WINDOW_LENGTH accepted samples
// and presents one result per window on a single-entry valid/ready output.
module audio_peak_window
    import audio_meter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DATA_WIDTH_DEFAULT,
    parameter int unsigned WINDOW_LENGTH = WINDOW_LENGTH_DEFAULT,
    parameter int unsigned COUNT_WIDTH   = $clog2(WINDOW_LENGTH)
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_clip
);

    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(WINDOW_LENGTH - 1);

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [DATA_WIDTH-1:0]  peak_q, peak_d;
    logic                   clip_acc_q, clip_acc_d;
    logic [DATA_WIDTH-1:0]  o_data_q, o_data_d;
    logic                   o_clip_q, o_clip_d;
    logic                   o_valid_q, o_valid_d;

    logic [DATA_WIDTH-1:0]  mag;
    logic                   sample_clip;
    logic [DATA_WIDTH-1:0]  peak_max;
    logic                   last;
    logic                   take;

    signed_magnitude #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_signed_magnitude (
        .i_data (i_data),
        .o_mag  (mag),
        .o_clip (sample_clip)
    );

    always_comb begin
        last     = (count_q == LAST_COUNT);
        // Stall only the window-closing sample, and only while the held result is unaccepted.
        i_ready  = !(last && o_valid_q && !o_ready);
        take     = i_valid && i_ready;
        peak_max = (mag > peak_q) ? mag : peak_q;
    end

    always_comb begin
        count_d    = count_q;
        peak_d     = peak_q;
        clip_acc_d = clip_acc_q;
        o_data_d   = o_data_q;
        o_clip_d   = o_clip_q;
        o_valid_d  = o_valid_q;

        if (o_valid_q && o_ready) begin
            o_valid_d = 1'b0;
        end

        if (take) begin
            if (last) begin
                o_data_d  = peak_max;
                o_clip_d  = clip_acc_q | sample_clip;
                o_valid_d = 1'b1;
                count_d   = '0;
            end else if (count_q == '0) begin
                // First sample of a window loads rather than comparing against the stale peak.
                peak_d     = mag;
                clip_acc_d = sample_clip;
                count_d    = count_q + COUNT_WIDTH'(1);
            end else begin
                peak_d     = peak_max;
                clip_acc_d = clip_acc_q | sample_clip;
                count_d    = count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            count_q    <= '0;
            peak_q     <= '0;
            clip_acc_q <= 1'b0;
            o_data_q   <= '0;
            o_clip_q   <= 1'b0;
            o_valid_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            peak_q     <= peak_d;
            clip_acc_q <= clip_acc_d;
            o_data_q   <= o_data_d;
            o_clip_q   <= o_clip_d;
            o_valid_q  <= o_valid_d;
        end
    end

    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_clip  = o_clip_q;

endmodule

// File: tb/tb_audio_peak_window.sv
// Self-checking bench for audio_peak_window with DATA_WIDTH=16 and WINDOW_LENGTH=4; directed
// scenarios plus a randomized run scored against a window-level reference model.
module tb_audio_peak_window;

    localparam int unsigned DW = 16;
    localparam int unsigned WL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic          o_ready;
    logic [DW-1:0] o_data;
    logic          o_clip;

    int n_checks = 0;
    int n_fail   = 0;

    logic rand_ready_en = 1'b0;
    logic [DW:0] got_q[$];

    always #5 clk = ~clk;

    audio_peak_window #(
        .DATA_WIDTH    (DW),
        .WINDOW_LENGTH (WL)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_data  (i_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_data  (o_data),
        .o_clip  (o_clip)
    );

    // Records every accepted result, {data, clip}.
    always @(posedge clk) begin
        if (!rst && o_valid && o_ready) got_q.push_back({o_data, o_clip});
    end

    always @(posedge clk) begin
        if (rand_ready_en) begin
            #1;
            o_ready = ($urandom_range(99) < 60);
        end
    end

    // Reference: peak |sample| over a window and whether any sample was full scale.
    function automatic logic [DW:0] model_window(input int s0, input int s1, input int s2,
                                                  input int s3);
        int s[4];
        int peak;
        logic clip;
        s = '{s0, s1, s2, s3};
        peak = 0;
        clip = 1'b0;
        foreach (s[k]) begin
            int m;
            m = (s[k] < 0) ? -s[k] : s[k];
            if (m > peak) peak = m;
            if (s[k] == 32767 || s[k] == -32768) clip = 1'b1;
        end
        return {peak[DW-1:0], clip};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one sample, optionally after random idle cycles, and returns just after it is taken.
    task automatic push_sample(input int s, input int idle_pct);
        while ($urandom_range(99) < idle_pct) begin
            i_valid = 1'b0;
            step();
        end
        i_valid = 1'b1;
        i_data  = DW'(s);
        for (int t = 0; t < 500; t++) begin
            @(negedge clk);
            if (i_ready) begin
                step();
                i_valid = 1'b0;
                return;
            end
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL push_timeout: sample %0d not accepted, i_ready=%b required 1", s, i_ready);
        i_valid = 1'b0;
    endtask

    task automatic push_window(input int s0, input int s1, input int s2, input int s3,
                               input int idle_pct);
        push_sample(s0, idle_pct);
        push_sample(s1, idle_pct);
        push_sample(s2, idle_pct);
        push_sample(s3, idle_pct);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        i_valid = 1'b0;
        i_data  = '0;
        o_ready = 1'b1;
        do_reset();
        n_checks++;
        if ({o_valid, o_data, o_clip, i_ready} !== {1'b0, 16'h0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: got valid=%b data=%h clip=%b ready=%b required 0 0000 0 1",
                     o_valid, o_data, o_clip, i_ready);
        end
    endtask

    task automatic test_basic_window();
        o_ready = 1'b1;
        push_window(100, -300, 200, 50, 0);
        n_checks++;
        if ({o_valid, o_data, o_clip} !== {1'b1, 16'd300, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_result: got valid=%b data=%0d clip=%b required 1 300 0",
                     o_valid, o_data, o_clip);
        end
        step();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pulse: o_valid=%b required 0 one cycle after", o_valid);
        end
    endtask

    task automatic test_full_scale();
        o_ready = 1'b1;
        push_window(0, -32768, 5, 7, 0);
        n_checks++;
        if ({o_valid, o_data, o_clip} !== {1'b1, 16'h8000, 1'b1}) begin
            n_fail++;
            $display("FAIL fs_negative: got valid=%b data=%h clip=%b required 1 8000 1",
                     o_valid, o_data, o_clip);
        end
        push_window(32767, 0, 0, 0, 0);
        n_checks++;
        if ({o_valid, o_data, o_clip} !== {1'b1, 16'd32767, 1'b1}) begin
            n_fail++;
            $display("FAIL fs_positive: got valid=%b data=%0d clip=%b required 1 32767 1",
                     o_valid, o_data, o_clip);
        end
        step();
    endtask

    task automatic test_isolation();
        o_ready = 1'b1;
        push_window(-32768, 1000, 0, 0, 0);
        push_window(10, 20, 30, 40, 0);
        n_checks++;
        if ({o_valid, o_data, o_clip} !== {1'b1, 16'd40, 1'b0}) begin
            n_fail++;
            $display("FAIL isolation: got valid=%b data=%0d clip=%b required 1 40 0",
                     o_valid, o_data, o_clip);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic [DW:0] exp1, exp2;
        exp1 = model_window(7, -900, 12, 3);
        exp2 = model_window(-1, 2, -3, 555);
        o_ready = 1'b0;
        push_window(7, -900, 12, 3, 0);
        push_sample(-1, 0);
        push_sample(2, 0);
        push_sample(-3, 0);
        i_valid = 1'b1;
        i_data  = DW'(555);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_checks++;
            if ({i_ready, o_valid, o_data, o_clip} !== {1'b0, 1'b1, exp1}) begin
                n_fail++;
                $display("FAIL bp_stall: ready=%b valid=%b data=%0d clip=%b required 0 1 %0d %b",
                         i_ready, o_valid, o_data, o_clip, exp1[DW:1], exp1[0]);
            end
            step();
        end
        o_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (i_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_release: i_ready=%b required 1", i_ready);
        end
        step();
        i_valid = 1'b0;
        n_checks++;
        if ({o_valid, o_data, o_clip} !== {1'b1, exp2}) begin
            n_fail++;
            $display("FAIL bp_reload: got valid=%b data=%0d clip=%b required 1 %0d %b",
                     o_valid, o_data, o_clip, exp2[DW:1], exp2[0]);
        end
        step();
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain: o_valid=%b required 0", o_valid);
        end
    endtask

    task automatic test_idle_gaps();
        o_ready = 1'b1;
        push_sample(-5, 50);
        push_sample(9, 50);
        push_sample(-12, 50);
        n_checks++;
        if (o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_early: o_valid=%b required 0 before 4th sample", o_valid);
        end
        push_sample(3, 50);
        n_checks++;
        if ({o_valid, o_data, o_clip} !== {1'b1, 16'd12, 1'b0}) begin
            n_fail++;
            $display("FAIL idle_result: got valid=%b data=%0d clip=%b required 1 12 0",
                     o_valid, o_data, o_clip);
        end
        step();
    endtask

    task automatic test_reset_mid();
        o_ready = 1'b0;
        push_window(-32768, 2000, 1, 1, 0);
        push_sample(9000, 0);
        push_sample(-8000, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++;
        if ({o_valid, o_data, o_clip} !== {1'b0, 16'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_mid: got valid=%b data=%h clip=%b required 0 0000 0",
                     o_valid, o_data, o_clip);
        end
        o_ready = 1'b1;
        push_window(1, 2, 3, 4, 0);
        n_checks++;
        if ({o_valid, o_data, o_clip} !== {1'b1, 16'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_fresh: got valid=%b data=%0d clip=%b required 1 4 0",
                     o_valid, o_data, o_clip);
        end
        step();
    endtask

    task automatic test_random();
        localparam int NW = 24;
        int smp[NW*4];
        logic [DW:0] exp;
        for (int i = 0; i < NW*4; i++) begin
            logic signed [DW-1:0] r;
            case ($urandom_range(9))
                0:       r = 16'sh7fff;
                1:       r = 16'sh8000;
                2:       r = DW'($urandom_range(15)) - 16'sd8;
                default: r = DW'($urandom_range(65535));
            endcase
            smp[i] = int'(r);
        end
        step();
        got_q.delete();
        rand_ready_en = 1'b1;
        for (int w = 0; w < NW; w++) begin
            push_window(smp[4*w], smp[4*w+1], smp[4*w+2], smp[4*w+3], 30);
        end
        rand_ready_en = 1'b0;
        step();
        o_ready = 1'b1;
        for (int c = 0; c < 4; c++) step();
        n_checks++;
        if (got_q.size() != NW) begin
            n_fail++;
            $display("FAIL rand_count: got %0d results required %0d", got_q.size(), NW);
        end
        for (int w = 0; w < NW && w < got_q.size(); w++) begin
            exp = model_window(smp[4*w], smp[4*w+1], smp[4*w+2], smp[4*w+3]);
            n_checks++;
            if (got_q[w] !== exp) begin
                n_fail++;
                $display("FAIL rand_window%0d: got data=%0d clip=%b required %0d %b", w,
                         got_q[w][DW:1], got_q[w][0], exp[DW:1], exp[0]);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_data  = '0;
        o_ready = 1'b1;
        test_reset();
        test_basic_window();
        test_full_scale();
        test_isolation();
        test_back_to_back();
        test_idle_gaps();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
